// File: rtl/digit_scan_mux.sv
// digit_scan_mux: N-digit common-cathode scanner with dead-time.
// `define DIGIT_SCAN_DIM_EN adds duty[3:0] PWM dimming.
`timescale 1ns/1ps
module digit_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 500,
  parameter int VAL_W      = 4,
  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = $clog2(SCAN_DIV)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic [NUM_DIGITS*VAL_W-1:0] digit_vals,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
`ifdef DIGIT_SCAN_DIM_EN
  input  logic [3:0]                  duty,
`endif
  output logic [NUM_DIGITS-1:0]       ct,
  output logic [IDX_W-1:0]            digit_idx,
  output logic [VAL_W-1:0]            val_out,
  output logic                        frame_tick
);

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_CNT =
    CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      val_q, val_d;
  logic [NUM_DIGITS-1:0] ct_q, ct_d;
  logic                  tick_q, tick_d;
  logic                  slot_end;
  logic                  lit;

`ifdef DIGIT_SCAN_DIM_EN
  logic [3:0] pwm_q, pwm_d;

  // Free-running dimming phase counter.
  always_comb begin
    pwm_d = pwm_q + 4'd1;
  end

  // PWM phase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`endif

  // Slot counter, digit index and frame pulse.
  always_comb begin
    slot_end = en && (cnt_q == LAST_CNT);
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tick_d   = 1'b0;
    unique case (1'b1)
      !en: begin
        cnt_d = '0;
      end
      slot_end: begin
        cnt_d  = '0;
        tick_d = (idx_q == LAST_IDX);
        idx_d  = (idx_q == LAST_IDX) ?
                 '0 : idx_q + 1'b1;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
      end
    endcase
  end

  // DEAD/ON sequencing within a slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DEAD: begin
        if (en && (cnt_d == DEAD_CNT))
          state_d = ST_ON;
      end
      ST_ON: begin
        if (!en || slot_end)
          state_d = ST_DEAD;
      end
      default: begin
        state_d = ST_DEAD;
      end
    endcase
  end

  // Value is captured as a slot begins and held.
  always_comb begin
    val_d = val_q;
    if (cnt_d == '0)
      val_d = digit_vals[idx_d*VAL_W +: VAL_W];
  end

  // One-cold cathode drive for the next cycle.
  always_comb begin
    lit = (state_d == ST_ON) && !blank_mask[idx_d];
`ifdef DIGIT_SCAN_DIM_EN
    lit = lit && (pwm_d < duty);
`endif
    ct_d = '1;
    if (lit)
      ct_d = ~(NUM_DIGITS'(1) << idx_d);
  end

  // Scan state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      state_q <= ST_DEAD;
      idx_q   <= '0;
      val_q   <= '0;
      ct_q    <= '1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      ct_q    <= ct_d;
      tick_q  <= tick_d;
    end
  end

  assign ct         = ct_q;
  assign digit_idx  = idx_q;
  assign val_out    = val_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: scoreboard bench for digit_scan_mux.
// Covers a 4-digit instance and a 1-digit instance.
`timescale 1ns/1ps
module tb_digit_scan_mux;
  localparam int N   = 4;
  localparam int SD  = 8;
  localparam int DC  = 2;
  localparam int VW  = 4;
  localparam int SD1 = 4;
  localparam int DC1 = 1;

  typedef struct {
    logic [N-1:0]  ct;
    logic [1:0]    idx;
    logic [VW-1:0] val;
    logic          tick;
    logic          ct1;
    logic [VW-1:0] val1;
    logic          tick1;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic en1;
  logic [N*VW-1:0] digit_vals;
  logic [N-1:0]    blank_mask;
  logic [VW-1:0]   vals1;
  logic            blank1;
  logic [N-1:0]    ct;
  logic [1:0]      digit_idx;
  logic [VW-1:0]   val_out;
  logic            frame_tick;
  logic            ct1;
  logic            idx1;
  logic [VW-1:0]   val1;
  logic            tick1;
`ifdef DIGIT_SCAN_DIM_EN
  logic [3:0]      duty;
`endif

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int            m_cnt, m_idx, m_pwm, p1;
  logic [VW-1:0] m_val, m_val1;
  logic          m_tick, m_tick1, m_ct1;
  logic [N-1:0]  m_ct;

  always #5 clk = ~clk;

  digit_scan_mux #(
    .NUM_DIGITS(N), .SCAN_DIV(SD),
    .DEAD_CYC(DC), .VAL_W(VW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .digit_vals(digit_vals),
    .blank_mask(blank_mask),
`ifdef DIGIT_SCAN_DIM_EN
    .duty(duty),
`endif
    .ct(ct), .digit_idx(digit_idx),
    .val_out(val_out), .frame_tick(frame_tick)
  );

  digit_scan_mux #(
    .NUM_DIGITS(1), .SCAN_DIV(SD1),
    .DEAD_CYC(DC1), .VAL_W(VW)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en1),
    .digit_vals(vals1),
    .blank_mask(blank1),
`ifdef DIGIT_SCAN_DIM_EN
    .duty(duty),
`endif
    .ct(ct1), .digit_idx(idx1),
    .val_out(val1), .frame_tick(tick1)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, req);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_pwm = 0;
    m_val = '0; m_tick = 0; m_ct = '1;
    p1 = 0; m_val1 = '0; m_tick1 = 0; m_ct1 = 1;
  endtask

  task automatic model_step();
    logic lit;
    logic lit1;
    if (!en) begin
      m_cnt = 0; m_tick = 0;
    end else if (m_cnt == SD-1) begin
      m_cnt  = 0;
      m_tick = (m_idx == N-1);
      m_idx  = (m_idx + 1) % N;
    end else begin
      m_cnt++; m_tick = 0;
    end
    if (m_cnt == 0)
      m_val = digit_vals[m_idx*VW +: VW];
    m_pwm = (m_pwm + 1) % 16;
    lit = en && (m_cnt >= DC) && !blank_mask[m_idx];
    p1 = (p1 + 1) % SD1;
    m_tick1 = (p1 == 0);
    if (p1 == 0) m_val1 = vals1;
    lit1 = (p1 >= DC1);
`ifdef DIGIT_SCAN_DIM_EN
    lit  = lit  && (m_pwm < duty);
    lit1 = lit1 && (m_pwm < duty);
`endif
    m_ct  = lit ? ~(4'b0001 << m_idx) : 4'b1111;
    m_ct1 = !lit1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.ct = m_ct; e.idx = 2'(m_idx);
    e.val = m_val; e.tick = m_tick;
    e.ct1 = m_ct1; e.val1 = m_val1;
    e.tick1 = m_tick1;
    q.push_back(e);
  endtask

  task automatic cyc();
    model_step();
    push_exp();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_until(input int ti,
                           input int tc);
    int n;
    n = 0;
    while (!(m_idx == ti && m_cnt == tc) && n < 64) begin
      cyc();
      n++;
    end
    if (n >= 64) begin
      errors++;
      $display("FAIL run_until: slot %0d pos %0d",
               ti, tc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ct", ct, e.ct);
        chk("digit_idx", digit_idx, e.idx);
        chk("val_out", val_out, e.val);
        chk("frame_tick", frame_tick, e.tick);
        chk("one_cold", $countones(~ct) <= 1, 1);
        chk("n1_ct", ct1, e.ct1);
        chk("n1_idx", idx1, 0);
        chk("n1_val", val1, e.val1);
        chk("n1_tick", tick1, e.tick1);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    en = 1'b0; en1 = 1'b1;
    digit_vals = 16'hA5C3;
    blank_mask = '0;
    vals1 = 4'h9; blank1 = 1'b0;
`ifdef DIGIT_SCAN_DIM_EN
    duty = 4'd15;
`endif
    model_reset();
    @(negedge clk);
    push_exp();
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    cycles(96);
    run_until(3, 7);
    cycles(3);
    digit_vals = 16'h1234;
    cycles(5);
    cycles(24);
    blank_mask = 4'b0100;
    cycles(32);
    blank_mask = '0;
    run_until(1, 4);
    en = 1'b0;
    cycles(5);
    en = 1'b1;
    cycles(16);
    run_until(3, 7);
    en = 1'b0;
    cyc();
    en = 1'b1;
    cycles(20);
    run_until(2, 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_ct", ct, 4'b1111);
    chk("async_idx", digit_idx, 0);
    chk("async_val", val_out, 0);
    chk("async_tick", frame_tick, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycles(40);
`ifdef DIGIT_SCAN_DIM_EN
    duty = 4'd4;
    cycles(64);
    duty = 4'd0;
    cycles(32);
    duty = 4'd15;
    cycles(16);
`endif
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
